// File: rtl/note_decoder.sv
// note_decoder: recovers the sounding key from a square-wave tone by timing
// rising-edge spacing against a per-key period table, with run-length debounce.
module note_decoder #(
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 256,
    parameter int TOL        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sound,
    output logic [10:0] keys,
    output logic        note_valid,
    output logic        changed,
    output logic [15:0] period
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;
    localparam logic [10:0][15:0] P = {16'd74, 16'd70, 16'd66, 16'd62, 16'd59, 16'd56,
                                       16'd53, 16'd50, 16'd47, 16'd44, 16'd42};
    localparam logic [15:0] T  = 16'(TOL);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    localparam logic [3:0]  SC = 4'(STABLE_CNT);

    logic        s1, s2, s2_d, state, rise, same;
    logic [15:0] cnt;
    logic [10:0] cand, cls, cand_n;
    logic [3:0]  run, run_n;

    assign rise = s2 & ~s2_d;

    // class is the one-hot key whose window contains the count, 0 when none match
    for (genvar k = 0; k < 11; k++) begin : g_cls
        assign cls[k] = (cnt >= P[k] - T) && (cnt <= P[k] + T);
    end

    always_comb begin
        same   = cls == cand;
        cand_n = same ? cand : cls;
        run_n  = !same ? 4'd1 : (run >= SC ? SC : run + 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s2_d       <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            cand       <= '0;
            run        <= '0;
            keys       <= '0;
            note_valid <= 1'b0;
            changed    <= 1'b0;
            period     <= '0;
        end else begin
            s1      <= sound;
            s2      <= s1;
            s2_d    <= s2;
            changed <= 1'b0;
            if (state == IDLE) begin
                cnt <= rise ? 16'd1 : 16'd0;
                if (rise) state <= MEASURE;
            end else if (rise) begin
                period <= cnt;
                cnt    <= 16'd1;
                cand   <= cand_n;
                run    <= run_n;
                if (run_n == SC && cand_n != keys) begin
                    keys       <= cand_n;
                    note_valid <= |cand_n;
                    changed    <= 1'b1;
                end
            end else if (cnt >= TO) begin
                state      <= IDLE;
                cnt        <= '0;
                cand       <= '0;
                run        <= '0;
                keys       <= '0;
                note_valid <= 1'b0;
                changed    <= |keys;
            end else begin
                cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_note_decoder.sv
// tb_note_decoder: directed table of tone streams plus timeout and reset sequences.
module tb_note_decoder;
    logic        clk = 1'b0, rst = 1'b1, sound = 1'b0;
    logic [10:0] keys;
    logic        note_valid, changed;
    logic [15:0] period;
    int          tests = 0, fails = 0, nchg = 0;

    note_decoder dut (
        .clk(clk), .rst(rst), .sound(sound),
        .keys(keys), .note_valid(note_valid), .changed(changed), .period(period)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (changed) nchg++;

    typedef struct {
        int          p;
        int          n;
        logic [10:0] k;
        logic        nv;
        logic [15:0] per;
        int          chg;
    } rec_t;
    rec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int p);
        sound = 1'b1;
        repeat (p / 2) @(negedge clk);
        sound = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic state_chk(input string tag, input logic [10:0] k, input logic nv,
                             input logic [15:0] per, input int chg);
        chk({tag, ".keys"}, 32'(keys), 32'(k));
        chk({tag, ".valid"}, 32'(note_valid), 32'(nv));
        chk({tag, ".period"}, 32'(period), 32'(per));
        chk({tag, ".changed_cnt"}, 32'(nchg), 32'(chg));
    endtask

    initial begin
        tv[0]  = '{47, 1, 11'h000, 1'b0, 16'd0,  0};
        tv[1]  = '{47, 2, 11'h000, 1'b0, 16'd47, 0};
        tv[2]  = '{47, 1, 11'h004, 1'b1, 16'd47, 1};
        tv[3]  = '{47, 2, 11'h004, 1'b1, 16'd47, 1};
        tv[4]  = '{42, 1, 11'h004, 1'b1, 16'd47, 1};
        tv[5]  = '{42, 3, 11'h001, 1'b1, 16'd42, 2};
        tv[6]  = '{74, 3, 11'h001, 1'b1, 16'd74, 2};
        tv[7]  = '{74, 1, 11'h400, 1'b1, 16'd74, 3};
        tv[8]  = '{44, 4, 11'h002, 1'b1, 16'd44, 4};
        tv[9]  = '{45, 2, 11'h002, 1'b1, 16'd45, 4};
        tv[10] = '{45, 2, 11'h000, 1'b0, 16'd45, 5};
        tv[11] = '{50, 4, 11'h008, 1'b1, 16'd50, 6};
        tv[12] = '{44, 1, 11'h008, 1'b1, 16'd50, 6};
        tv[13] = '{50, 1, 11'h008, 1'b1, 16'd44, 6};
        tv[14] = '{44, 1, 11'h008, 1'b1, 16'd50, 6};
        tv[15] = '{50, 1, 11'h008, 1'b1, 16'd44, 6};
        tv[16] = '{53, 4, 11'h010, 1'b1, 16'd53, 7};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        state_chk("idle", 11'h000, 1'b0, 16'd0, 0);
        chk("idle.fsm", 32'(dut.state), 32'd0);

        for (int i = 0; i < 17; i++) begin
            repeat (tv[i].n) pulse(tv[i].p);
            state_chk($sformatf("vec%0d", i), tv[i].k, tv[i].nv, tv[i].per, tv[i].chg);
        end

        sound = 1'b1;
        repeat (250) @(negedge clk);
        chk("timeout.before", 32'(keys), 32'h010);
        repeat (15) @(negedge clk);
        state_chk("timeout", 11'h000, 1'b0, 16'd53, 8);
        repeat (40) @(negedge clk);
        sound = 1'b0;
        repeat (10) @(negedge clk);
        repeat (3) pulse(53);
        state_chk("rearm", 11'h000, 1'b0, 16'd53, 8);
        pulse(53);
        state_chk("recommit", 11'h010, 1'b1, 16'd53, 9);

        repeat (4) pulse(62);
        state_chk("p62", 11'h080, 1'b1, 16'd62, 10);
        sound = 1'b1;
        repeat (31) @(negedge clk);
        sound = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        state_chk("rst", 11'h000, 1'b0, 16'd0, 10);
        @(negedge clk);
        rst = 1'b0;
        repeat (26) @(negedge clk);
        repeat (3) pulse(62);
        state_chk("rst.rearm", 11'h000, 1'b0, 16'd62, 10);
        pulse(62);
        state_chk("rst.recommit", 11'h080, 1'b1, 16'd62, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
